spi_master: RTL

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_pkg.sv | 14 +
 rtl/spi_clk_div.sv | 32 +++
 rtl/spi_master.sv | 121 ++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared SPI constants: frame width and the master FSM state encoding,
// so the master and any slave partner agree on one width.
package spi_pkg;

  localparam int SPI_WIDTH = 13;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_LOAD = 2'd3
  } spi_state_e;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator: tick is high in the last clk cycle of every
// HALF_PERIOD-long window while enabled; clr restarts the window.
module spi_clk_div #(
  parameter int HALF_PERIOD = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(HALF_PERIOD - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  // With HALF_PERIOD=1 the counter sits at 0 and tick follows en every cycle.
  assign tick = en && !clr && (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/spi_master.sv
// SPI master, mode 0 style: sclk idles low, miso sampled on the rising
// sclk edge, mosi changes on the falling edge, load strobe closes the frame.
module spi_master import spi_pkg::*; #(
  parameter int WIDTH       = SPI_WIDTH,
  parameter int HALF_PERIOD = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] tx_data,
  output logic             busy,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             sclk,
  output logic             mosi,
  input  logic             miso,
  output logic             load
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  spi_state_e       state_q, state_d;
  logic [WIDTH-1:0] tx_sr_q, tx_sr_d;
  logic [WIDTH-1:0] rx_sr_q, rx_sr_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             sclk_q, sclk_d;
  logic             load_q, load_d;
  logic             busy_q, busy_d;
  logic             rx_valid_q, rx_valid_d;
  logic             accept;
  logic             tick;

  spi_clk_div #(.HALF_PERIOD(HALF_PERIOD)) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state_q != ST_IDLE),
    .clr   (accept),
    .tick  (tick)
  );

  always_comb begin
    state_d    = state_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    rx_data_d  = rx_data_q;
    bit_cnt_d  = bit_cnt_q;
    sclk_d     = sclk_q;
    load_d     = load_q;
    busy_d     = busy_q;
    rx_valid_d = 1'b0;
    accept     = 1'b0;
    unique case (state_q)
      ST_IDLE: if (start) begin
        accept    = 1'b1;
        state_d   = ST_LOW;
        tx_sr_d   = tx_data;
        bit_cnt_d = '0;
        busy_d    = 1'b1;
      end
      ST_LOW: if (tick) begin
        state_d = ST_HIGH;
        sclk_d  = 1'b1;
        rx_sr_d = {rx_sr_q[WIDTH-2:0], miso};
      end
      ST_HIGH: if (tick) begin
        sclk_d = 1'b0;
        if (bit_cnt_q == LAST_BIT) begin
          state_d = ST_LOAD;
          load_d  = 1'b1;
        end else begin
          state_d   = ST_LOW;
          bit_cnt_d = bit_cnt_q + 1'b1;
          tx_sr_d   = {tx_sr_q[WIDTH-2:0], 1'b0};
        end
      end
      ST_LOAD: if (tick) begin
        state_d    = ST_IDLE;
        load_d     = 1'b0;
        rx_data_d  = rx_sr_q;
        rx_valid_d = 1'b1;
        busy_d     = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      rx_data_q  <= '0;
      bit_cnt_q  <= '0;
      sclk_q     <= 1'b0;
      load_q     <= 1'b0;
      busy_q     <= 1'b0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      rx_data_q  <= rx_data_d;
      bit_cnt_q  <= bit_cnt_d;
      sclk_q     <= sclk_d;
      load_q     <= load_d;
      busy_q     <= busy_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  // mosi is the tx shift register MSB, so it holds its last bit in IDLE.
  assign mosi     = tx_sr_q[WIDTH-1];
  assign sclk     = sclk_q;
  assign load     = load_q;
  assign busy     = busy_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

endmodule
